// File: rtl/reg_slice_rr_arb_if.sv
// ---------------------------------------------------------------------------
// reg_slice_rr_arb_if
//
// Handshake bundle for the round-robin arbiter register slice.
//   Upstream (requesters) : s_pld[REQ_NUM], s_vld, s_last  -> arbiter
//                           s_rdy (one-hot or zero)        <- arbiter
//   Downstream            : m_pld, m_vld, m_last, m_id     <- arbiter
//                           m_rdy                          -> arbiter
// Modports:
//   slave  - the arbiter's view (takes requests, drives the output stage)
//   master - the environment's view (drives requests, consumes output)
// ---------------------------------------------------------------------------
interface reg_slice_rr_arb_if #(
    parameter type PLD_TYPE = logic,
    parameter int  REQ_NUM  = 4,
    parameter int  ID_W     = $clog2(REQ_NUM)
);
    PLD_TYPE              s_pld [REQ_NUM];
    logic [REQ_NUM-1:0]   s_vld;
    logic [REQ_NUM-1:0]   s_last;
    logic [REQ_NUM-1:0]   s_rdy;
    PLD_TYPE              m_pld;
    logic                 m_vld;
    logic                 m_last;
    logic [ID_W-1:0]      m_id;
    logic                 m_rdy;

    modport slave (
        input  s_pld, s_vld, s_last, m_rdy,
        output s_rdy, m_pld, m_vld, m_last, m_id
    );

    modport master (
        output s_pld, s_vld, s_last, m_rdy,
        input  s_rdy, m_pld, m_vld, m_last, m_id
    );
endinterface

// File: rtl/reg_slice_rr_arb.sv
// ---------------------------------------------------------------------------
// reg_slice_rr_arb
//
// N-to-1 round-robin arbiter feeding a full-throughput output stage
// (main register + skid register). The winning requester's payload, last
// flag and index travel together through the stage.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset (clears every register)
//   bus  - reg_slice_rr_arb_if.slave: s_pld/s_vld/s_last/s_rdy requester
//          side, m_pld/m_vld/m_last/m_id/m_rdy downstream side
//
// Build option:
//   REG_SLICE_ARB_LOCK_EN - when defined, a lock FSM holds the grant on a
//   requester from its first beat until its s_last beat, so packets are
//   never interleaved and the pointer advances once per packet. When
//   undefined, arbitration is per beat and s_last is only forwarded.
//
// Lock FSM states (present only with REG_SLICE_ARB_LOCK_EN):
//   state     | meaning
//   ST_IDLE   | free round-robin arbitration
//   ST_LOCKED | grant pinned to lock_id_q until its s_last beat is accepted
// ---------------------------------------------------------------------------
module reg_slice_rr_arb #(
    parameter type PLD_TYPE = logic,
    parameter int  REQ_NUM  = 4,
    parameter int  ID_W     = $clog2(REQ_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    reg_slice_rr_arb_if.slave  bus
);
    localparam int IDX_W = $clog2(REQ_NUM);
    localparam int SUM_W = IDX_W + 1;

    typedef logic [IDX_W-1:0] idx_t;

    idx_t               ptr_q, ptr_d;
    idx_t               ptr_nxt;

    idx_t               gnt_idx;
    logic               gnt_vld;
    idx_t               cand;
    logic [SUM_W-1:0]   cand_sum;

    logic               acc_rdy;
    logic               acc;
    logic               drain;
    logic [REQ_NUM-1:0] s_rdy_c;

    PLD_TYPE            in_pld;
    logic               in_last;

    logic               main_vld_q, main_vld_d;
    PLD_TYPE            main_pld_q, main_pld_d;
    logic               main_last_q, main_last_d;
    idx_t               main_id_q, main_id_d;

    logic               skid_vld_q, skid_vld_d;
    PLD_TYPE            skid_pld_q, skid_pld_d;
    logic               skid_last_q, skid_last_d;
    idx_t               skid_id_q, skid_id_d;

`ifdef REG_SLICE_ARB_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t        state_q;
    idx_t               lock_id_q;
`endif

    // Round-robin search: walking from the farthest candidate back to ptr
    // leaves the first valid index at or after ptr as the final winner.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        cand_sum = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr_q} + SUM_W'(k);
            if (cand_sum >= SUM_W'(REQ_NUM)) begin
                cand_sum = cand_sum - SUM_W'(REQ_NUM);
            end
            cand = cand_sum[IDX_W-1:0];
            if (bus.s_vld[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
`ifdef REG_SLICE_ARB_LOCK_EN
        // A locked packet owns the port even while its source is idle.
        if (state_q == ST_LOCKED) begin
            gnt_idx = lock_id_q;
            gnt_vld = bus.s_vld[lock_id_q];
        end
`endif
    end

    // Ready only depends on skid occupancy, so there is no m_rdy -> s_rdy path.
    assign acc_rdy = ~skid_vld_q;
    assign acc     = gnt_vld & acc_rdy;
    assign drain   = main_vld_q & bus.m_rdy;
    assign in_pld  = bus.s_pld[gnt_idx];
    assign in_last = bus.s_last[gnt_idx];

    always_comb begin
        s_rdy_c = '0;
        if (gnt_vld) begin
            s_rdy_c[gnt_idx] = acc_rdy;
        end
    end

    always_comb begin
        main_vld_d  = main_vld_q;
        main_pld_d  = main_pld_q;
        main_last_d = main_last_q;
        main_id_d   = main_id_q;
        skid_vld_d  = skid_vld_q;
        skid_pld_d  = skid_pld_q;
        skid_last_d = skid_last_q;
        skid_id_d   = skid_id_q;

        if (drain && skid_vld_q) begin
            // Skid occupied means acc_rdy=0, so no new beat competes here.
            main_pld_d  = skid_pld_q;
            main_last_d = skid_last_q;
            main_id_d   = skid_id_q;
            skid_vld_d  = 1'b0;
        end else if (drain || !main_vld_q) begin
            main_vld_d = acc;
            if (acc) begin
                main_pld_d  = in_pld;
                main_last_d = in_last;
                main_id_d   = gnt_idx;
            end
        end else if (acc) begin
            skid_vld_d  = 1'b1;
            skid_pld_d  = in_pld;
            skid_last_d = in_last;
            skid_id_d   = gnt_idx;
        end
    end

    always_comb begin
        ptr_nxt = (gnt_idx == idx_t'(REQ_NUM - 1)) ? '0 : gnt_idx + idx_t'(1);
        ptr_d   = ptr_q;
`ifdef REG_SLICE_ARB_LOCK_EN
        if (acc && in_last) begin
            ptr_d = ptr_nxt;
        end
`else
        if (acc) begin
            ptr_d = ptr_nxt;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            main_vld_q  <= 1'b0;
            main_pld_q  <= '0;
            main_last_q <= 1'b0;
            main_id_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_pld_q  <= '0;
            skid_last_q <= 1'b0;
            skid_id_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            main_vld_q  <= main_vld_d;
            main_pld_q  <= main_pld_d;
            main_last_q <= main_last_d;
            main_id_q   <= main_id_d;
            skid_vld_q  <= skid_vld_d;
            skid_pld_q  <= skid_pld_d;
            skid_last_q <= skid_last_d;
            skid_id_q   <= skid_id_d;
        end
    end

`ifdef REG_SLICE_ARB_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lock_id_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc && !in_last) begin
                        state_q   <= ST_LOCKED;
                        lock_id_q <= gnt_idx;
                    end
                end
                ST_LOCKED: begin
                    if (acc && in_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`endif

    assign bus.s_rdy  = s_rdy_c;
    assign bus.m_vld  = main_vld_q;
    assign bus.m_pld  = main_pld_q;
    assign bus.m_last = main_last_q;
    assign bus.m_id   = ID_W'(main_id_q);

endmodule

// File: doc/reg_slice_rr_arb.md
# reg_slice_rr_arb

N-to-1 round-robin arbiter with valid/ready handshakes on every port. It shares one downstream register-slice pipeline between `REQ_NUM` requesters. Each cycle the arbiter picks one valid requester, steers its payload into an internal full-throughput output stage (main register plus skid register), and reports which source won on `m_id`. It sits directly upstream of a `reg_slice_group` chain or a shared bus port.

## Interface
Parameters:
- `PLD_TYPE`, default `logic`: payload type.
- `REQ_NUM`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(REQ_NUM)`: width of `m_id`.

Ports:
- `clk`, input, 1: clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `s_pld`, input, `PLD_TYPE [REQ_NUM]`: requester payloads.
- `s_vld`, input, `[REQ_NUM]`: requester valid.
- `s_last`, input, `[REQ_NUM]`: last beat of a packet.
- `s_rdy`, output, `[REQ_NUM]`: requester ready. One-hot or zero.
- `m_pld`, output, `PLD_TYPE`: granted payload.
- `m_vld`, output, 1: output valid.
- `m_last`, output, 1: `s_last` of the forwarded beat.
- `m_id`, output, `ID_W`: index of the requester that sourced the beat.
- `m_rdy`, input, 1: downstream ready.

## Operation
- **Reset values:** `m_vld`=0, `m_pld`=0, `m_last`=0, `m_id`=0. Main and skid registers are empty. Priority pointer `ptr`=0. Lock FSM is IDLE. Every field is cleared; there is no no-data-reset option.
- **Grant:**
  - Combinational from `s_vld` and `ptr`.
  - Winner g = first index i with `s_vld[i]`=1, searched in the order ptr, ptr+1, …, REQ_NUM-1, 0, …, ptr-1.
  - No valid requester means no grant.
- **Ready:** `s_rdy[g]` = `acc_rdy`, and every other bit is 0. `acc_rdy` = skid register empty; it is a registered signal and has no combinational path from `m_rdy`.
- **Dependency rule:** `s_rdy` depends on `s_vld`. Requesters must not make `s_vld` depend on `s_rdy`. Once a requester raises `s_vld`, it holds `s_vld` and `s_pld` stable until the handshake completes.
- **Accept:** a beat is accepted when `s_vld[g]` & `s_rdy[g]`. It is written to the main register if the main register is empty or is draining (`m_rdy`=1) this cycle. Otherwise it is written to the skid register.
- **Drain:** when `m_vld` & `m_rdy`, the main register is loaded from the skid register if the skid is occupied, and cleared otherwise.
- **Pointer update:** on an accepted beat from g, `ptr` ← (g+1) mod REQ_NUM. With the lock feature compiled in, `ptr` updates only on the accepted beat that has `s_last`=1. Wrap-around: g = REQ_NUM-1 gives `ptr`=0.
- **Lock FSM** (only with the Configuration macro defined):
  - States are IDLE and LOCKED(id).
  - IDLE → LOCKED(g) on an accepted beat with `s_last`=0.
  - In LOCKED(id), the grant is forced to id regardless of other requesters' `s_vld`. If `s_vld[id]`=0, there is no grant and all `s_rdy` bits are 0.
  - LOCKED → IDLE on an accepted beat from id with `s_last`=1.
  - A single-beat packet (`s_last`=1 in IDLE) never enters LOCKED.
- **Reset mid-packet:** the FSM returns to IDLE, buffered beats are discarded, and `ptr`=0.

## Timing
- **Latency:** a beat accepted at edge t appears on `m_vld`/`m_pld` after edge t, so the latency is 1 cycle.
- **Throughput:** 1 beat per cycle sustained with `m_rdy`=1, including alternation between different requesters on consecutive cycles.
- **Backpressure:** with `m_rdy`=0 and the main register full, at most one more beat is accepted, into the skid register. `acc_rdy` is 0 from the next cycle until the skid drains.
- **Simultaneous accept and drain:** when the skid is empty, the new beat goes directly to the main register, with no bubble.
- **Ordering:** output order equals acceptance order. `m_id` and `m_last` travel with the beat.
- **Fairness:** with all requesters permanently valid and no lock, grants rotate 0,1,…,REQ_NUM-1. Each requester waits at most REQ_NUM-1 beats; with lock enabled, it waits at most REQ_NUM-1 packets.

## Configuration
- **`REG_SLICE_ARB_LOCK_EN` defined:** the lock FSM is present. Arbitration happens per packet, and packets are never interleaved on the output.
- **`REG_SLICE_ARB_LOCK_EN` undefined:**
  - Arbitration happens per beat and the pointer updates on every accepted beat.
  - `s_last` is ignored for grant purposes but is still forwarded on `m_last`.
  - No FSM state exists.

## Test plan
- **Reset state:** assert `rst` asynchronously between edges with beats buffered → `m_vld` drops to 0 immediately. After release: `ptr`=0 and all `s_rdy` are 0 while `s_vld`=0.
- **Round-robin rotation:** REQ_NUM=4, all `s_vld`=1, `m_rdy`=1, all `s_last`=1 → `m_id` sequence 0,1,2,3,0 on consecutive cycles, with no bubbles.
- **Backpressure:** requester 2 streams payloads 0xA0, 0xA1, 0xA2 while `m_rdy`=0 for 3 cycles.
  - 0xA0 is held in the main register, 0xA1 in the skid register, and `s_rdy[2]`=0 on the third cycle.
  - After `m_rdy`=1, the output is 0xA0, 0xA1, 0xA2 in order, with nothing lost or duplicated.
- **Packet lock (macro defined):** requester 1 sends 3 beats with `s_last`=0,0,1 while requester 3 is valid throughout.
  - All 3 beats from requester 1 are output first, and requester 3 stalls.
  - `m_id`=3 appears next, and afterwards `ptr`=2.
- **Lock disabled (macro undefined):** same stimulus as the packet-lock test → output `m_id` interleaves 1,3,1,3,1.
- **Wrap and sparse requests:** `ptr`=3 and only `s_vld[0]` and `s_vld[2]` are set → grant goes to 0, then to 2.
